// File: rtl/i2c_pkg.sv
// Shared definitions for the two-requester I2C command arbiter.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    localparam int START_CYCLES_DEF = 2;
    localparam int BUSY_TIMEOUT_DEF = 64;
    localparam int MAX_RETRY_DEF    = 1;

endpackage

// File: rtl/i2c_arbiter_if.sv
// Command/status bus between the arbiter (master side) and the I2C master core (slave side).
interface i2c_arbiter_if;

    logic       m_start;
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic [7:0] m_data_out;
    logic       m_ack_error;
    logic       m_busy;

    modport master (
        output m_start, m_addr, m_data_in, m_rw,
        input  m_data_out, m_ack_error, m_busy
    );

    modport slave (
        input  m_start, m_addr, m_data_in, m_rw,
        output m_data_out, m_ack_error, m_busy
    );

endinterface

// File: rtl/i2c_rr_pick.sv
// Two-way round-robin pick: when both request, the one not served last wins.
module i2c_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: default assignment first so no path leaves grant unassigned (no latch).
        grant = req;
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates two requesters onto one I2C master core, with start pulse, busy timeout
// and a bounded number of re-issues on slave NACK.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int START_CYCLES = START_CYCLES_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
    parameter int MAX_RETRY    = MAX_RETRY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [6:0] addr0,
    input  logic [6:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata,
    output logic       err,
    output logic       timeout,
    output logic       arb_busy,
    i2c_arbiter_if.master bus
);

    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  retry;
    logic        last;
    logic        sel;
    logic [7:0]  cap_data;
    logic        cap_nack;
    logic        to_flag;
    logic [1:0]  pick;

    i2c_rr_pick u_pick (
        .req   ({req1, req0}),
        .last  (last),
        .grant (pick)
    );

    assign arb_busy = (state != IDLE);

    // NOTE: all state and outputs use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            retry         <= '0;
            last          <= 1'b1;
            sel           <= 1'b0;
            cap_data      <= '0;
            cap_nack      <= 1'b0;
            to_flag       <= 1'b0;
            gnt0          <= 1'b0;
            gnt1          <= 1'b0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            rdata         <= '0;
            err           <= 1'b0;
            timeout       <= 1'b0;
            bus.m_start   <= 1'b0;
            bus.m_addr    <= '0;
            bus.m_data_in <= '0;
            bus.m_rw      <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick != 2'b00) begin
                        gnt0          <= pick[0];
                        gnt1          <= pick[1];
                        sel           <= pick[1];
                        last          <= pick[1];
                        bus.m_rw      <= pick[1] ? rw1    : rw0;
                        bus.m_addr    <= pick[1] ? addr1  : addr0;
                        bus.m_data_in <= pick[1] ? wdata1 : wdata0;
                        bus.m_start   <= 1'b1;
                        cnt           <= '0;
                        to_flag       <= 1'b0;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt == 16'(START_CYCLES - 1)) begin
                        bus.m_start <= 1'b0;
                        cnt         <= '0;
                        state       <= WAIT_BUSY;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_BUSY: begin
                    if (bus.m_busy) begin
                        state <= WAIT_DONE;
                    end else if (cnt == 16'(BUSY_TIMEOUT - 1)) begin
                        to_flag  <= 1'b1;
                        cap_nack <= 1'b0;
                        cap_data <= '0;
                        state    <= RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.m_busy) begin
                        // A NACK re-issues the same latched command while retries remain.
                        if (bus.m_ack_error && (retry < 8'(MAX_RETRY))) begin
                            retry       <= retry + 8'd1;
                            bus.m_start <= 1'b1;
                            cnt         <= '0;
                            state       <= ISSUE;
                        end else begin
                            cap_data <= bus.m_data_out;
                            cap_nack <= bus.m_ack_error;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    done0   <= ~sel;
                    done1   <= sel;
                    rdata   <= bus.m_rw ? cap_data : 8'h00;
                    err     <= cap_nack | to_flag;
                    timeout <= to_flag;
                    retry   <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a small behavioural I2C master core model.
module tb_i2c_arbiter;
    import i2c_pkg::*;

    localparam int START_CYCLES = 2;
    localparam int BUSY_TIMEOUT = 64;
    localparam int MAX_RETRY    = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, rw0 = 1'b0, rw1 = 1'b0;
    logic [6:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, done0, done1, err, timeout, arb_busy;
    logic [7:0] rdata;

    int checks = 0;
    int failures = 0;

    i2c_arbiter_if bus ();

    i2c_arbiter #(
        .START_CYCLES (START_CYCLES),
        .BUSY_TIMEOUT (BUSY_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .rw0      (rw0),
        .rw1      (rw1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .rdata    (rdata),
        .err      (err),
        .timeout  (timeout),
        .arb_busy (arb_busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Core model: busy for one cycle after m_start falls; only address 0x51 ACKs.
    logic       slave_dead = 1'b0;
    logic       busy_stuck = 1'b0;
    logic [7:0] slave_rdata = 8'h00;
    int         issue_count = 0;
    int         start_hi = 0;
    logic [6:0] cap_addr = '0;
    logic [7:0] cap_wdata = '0;
    logic       cap_rw = 1'b0;
    logic       prev_start = 1'b0;
    logic       busy_on = 1'b0;

    initial begin
        bus.m_busy      = 1'b0;
        bus.m_ack_error = 1'b0;
        bus.m_data_out  = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.m_start) begin
                start_hi++;
                if (!prev_start) begin
                    issue_count++;
                    cap_addr  = bus.m_addr;
                    cap_wdata = bus.m_data_in;
                    cap_rw    = bus.m_rw;
                end
            end
            if (prev_start && !bus.m_start && !slave_dead) begin
                bus.m_busy      = 1'b1;
                bus.m_ack_error = (bus.m_addr != 7'h51);
                bus.m_data_out  = slave_rdata;
                busy_on         = 1'b1;
            end else if (busy_on && !busy_stuck) begin
                bus.m_busy = 1'b0;
                busy_on    = 1'b0;
            end
            prev_start = bus.m_start;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic pulse_sig(input int which);
        case (which)
            0:       return gnt0;
            1:       return gnt1;
            2:       return done0;
            3:       return done1;
            4:       return gnt0 | gnt1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns the number of falling edges until the pulse is seen, or -1 when the budget runs out.
    task automatic wait_pulse(input int which, input int budget, output int lat);
        int k;
        lat = -1;
        k = 0;
        while (lat < 0 && k < budget) begin
            @(negedge clk);
            k++;
            if (pulse_sig(which)) lat = k;
        end
    endtask

    task automatic do_cmd(input string tag, input bit who, input bit rw, input logic [6:0] addr,
                          input logic [7:0] wdata, input int budget, output int lat);
        int gl;
        issue_count = 0;
        start_hi    = 0;
        if (who) begin
            req1 = 1'b1; rw1 = rw; addr1 = addr; wdata1 = wdata;
        end else begin
            req0 = 1'b1; rw0 = rw; addr0 = addr; wdata0 = wdata;
        end
        wait_pulse(who ? 1 : 0, 10, gl);
        check({tag, ".gnt"}, 32'(gl > 0), 32'd1);
        check({tag, ".other_gnt"}, 32'(who ? gnt0 : gnt1), 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        wait_pulse(who ? 3 : 2, budget, lat);
        check({tag, ".done"}, 32'(lat > 0), 32'd1);
    endtask

    task automatic rr_pair(input string tag);
        int l;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 7'h51; wdata0 = 8'h01;
        req1 = 1'b1; rw1 = 1'b0; addr1 = 7'h51; wdata1 = 8'h02;
        wait_pulse(4, 10, l);
        check({tag, ".first_is_0"}, 32'({gnt0, gnt1}), 32'b10);
        req0 = 1'b0;
        wait_pulse(2, 20, l);
        check({tag, ".done0"}, 32'(l > 0), 32'd1);
        wait_pulse(1, 10, l);
        check({tag, ".then_gnt1"}, 32'({gnt0, gnt1}), 32'b01);
        req1 = 1'b0;
        wait_pulse(3, 20, l);
        check({tag, ".done1"}, 32'(l > 0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ctrl"}, 32'({gnt0, gnt1, done0, done1, err, timeout, arb_busy, bus.m_start, bus.m_rw}), 32'd0);
        check({tag, ".rdata"}, 32'(rdata), 32'd0);
        check({tag, ".addr_data"}, 32'({bus.m_addr, bus.m_data_in}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  k;
        bit  seen;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Write to an ACKing slave: minimum latency path.
        slave_rdata = 8'hC3;
        do_cmd("wr51", 1'b0, 1'b0, 7'h51, 8'h3C, 20, lat);
        check("wr51.latency", 32'(lat), 32'(START_CYCLES + 3));
        check("wr51.start_cycles", 32'(start_hi), 32'(START_CYCLES));
        check("wr51.issues", 32'(issue_count), 32'd1);
        check("wr51.bus_cmd", 32'({cap_rw, cap_addr, cap_wdata}), 32'({1'b0, 7'h51, 8'h3C}));
        check("wr51.err_to", 32'({err, timeout}), 32'd0);
        check("wr51.rdata_zero", 32'(rdata), 32'd0);
        check("wr51.idle_at_done", 32'(arb_busy), 32'd0);

        // Read from requester 1.
        slave_rdata = 8'hA5;
        do_cmd("rd51", 1'b1, 1'b1, 7'h51, 8'h00, 20, lat);
        check("rd51.rdata", 32'(rdata), 32'hA5);
        check("rd51.err_to", 32'({err, timeout}), 32'd0);
        check("rd51.rw", 32'(cap_rw), 32'd1);
        repeat (4) @(negedge clk);
        check("rd51.rdata_hold", 32'({rdata, err}), 32'({8'hA5, 1'b0}));

        // No slave at 0x22: one retry, then NACK error.
        do_cmd("nak22", 1'b0, 1'b0, 7'h22, 8'h11, 40, lat);
        check("nak22.issues", 32'(issue_count), 32'(MAX_RETRY + 1));
        check("nak22.err_to", 32'({err, timeout}), 32'b10);
        check("nak22.rdata", 32'(rdata), 32'd0);

        // Core never raises busy: timeout.
        slave_dead = 1'b1;
        do_cmd("tmo", 1'b1, 1'b0, 7'h51, 8'h77, 200, lat);
        check("tmo.err_to", 32'({err, timeout}), 32'b11);
        check("tmo.issues", 32'(issue_count), 32'd1);
        check("tmo.lat_window", 32'(lat >= START_CYCLES + BUSY_TIMEOUT && lat <= START_CYCLES + BUSY_TIMEOUT + 2), 32'd1);
        slave_dead = 1'b0;

        // Round robin from reset, twice.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rr_pair("rr1");
        rr_pair("rr2");

        // Reset while waiting for the core to finish; requester 1 stays pending.
        busy_stuck = 1'b1;
        req0 = 1'b1; rw0 = 1'b0; addr0 = 7'h51; wdata0 = 8'h44;
        wait_pulse(0, 10, lat);
        check("rstmid.gnt0", 32'(lat > 0), 32'd1);
        req0 = 1'b0;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 7'h51;
        slave_rdata = 8'h5A;
        k = 0;
        while (!bus.m_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rstmid.busy_seen", 32'(bus.m_busy), 32'd1);
        @(negedge clk);
        check("rstmid.active", 32'(arb_busy), 32'd1);
        rst = 1'b0;
        busy_stuck = 1'b0;
        @(negedge clk);
        check_reset_outputs("rstmid");
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done0 | done1) seen = 1'b1;
        end
        check("rstmid.no_done", 32'(seen), 32'd0);
        rst = 1'b1;
        wait_pulse(1, 10, lat);
        check("rstmid.regrant1", 32'(lat > 0), 32'd1);
        req1 = 1'b0;
        wait_pulse(3, 20, lat);
        check("rstmid.done1", 32'(lat > 0), 32'd1);
        check("rstmid.rdata", 32'({rdata, err, timeout}), 32'({8'h5A, 2'b00}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
